crc8_stream_gen: RTL

Streaming, parametrised CRC-8 engine for the UALink turbo64 datapath. Accepts frames as a sequence of DATA_WIDTH-bit beats over a valid/ready handshake and accumulates the CRC across beats, with byte-granular masking on the final beat. Emits one registered CRC per frame on a separate valid/ready output. Succeeds the single-word combinational CRC-8 generator; sits between the flit packer and the link transmit/receive-check stages.

---
 rtl/crc8_pkg.sv | 26 ++
 rtl/crc8_fold.sv | 33 +++
 rtl/crc8_stream_gen.sv | 87 ++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// crc8_pkg: shared constants and the per-byte CRC-8 step for the streaming CRC engine.
// Contents:
//   CRC8_POLY_DEFAULT - default generator polynomial (implicit x^8)
//   CRC8_INIT_DEFAULT - default accumulator value at frame start
//   crc8_byte()       - one MSB-first, non-reflected byte step
// Optional feature macro used by the engine: CRC8_CHECK_EN.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
    localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

    // Folding the whole byte into the register first and then shifting eight
    // times is equivalent to feeding the byte in bit by bit, MSB first.
    function automatic logic [7:0] crc8_byte(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/crc8_fold.sv
// crc8_fold: combinational fold of one beat into a running CRC-8.
// Ports:
//   crc_in  - running CRC before this beat
//   data    - beat data, byte [DATA_WIDTH-1 -: 8] folded first
//   keep    - byte enables, MSB = first byte
//   mask_en - 1: only bytes with keep set are folded; 0: every byte is folded
//   crc_out - running CRC after this beat
module crc8_fold
    import crc8_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [7:0]  POLY       = CRC8_POLY_DEFAULT
) (
    input  logic [7:0]              crc_in,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] keep,
    input  logic                    mask_en,
    output logic [7:0]              crc_out
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    // Disabled bytes pass the CRC through untouched, so a non-contiguous
    // keep simply folds the enabled bytes in MSB-first order.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < NB; i++)
            crc_out = (!mask_en || keep[NB-1-i])
                    ? crc8_byte(crc_out, data[DATA_WIDTH-1-8*i -: 8], POLY)
                    : crc_out;
    end

endmodule

// File: rtl/crc8_stream_gen.sv
// crc8_stream_gen: streaming CRC-8 over DATA_WIDTH-bit beats with a one-slot registered result.
// Ports:
//   axi_aclk, axi_resetn              - clock (rising edge), synchronous active-low reset
//   s_valid, s_ready, s_data,
//   s_keep, s_last                    - input beat stream; s_keep honoured on the last beat only
//   m_valid, m_ready, m_crc           - per-frame CRC result stream
//   s_crc_rx, m_err, err_cnt          - received CRC compare and saturating mismatch counter,
//                                       present only when CRC8_CHECK_EN is defined
module crc8_stream_gen
    import crc8_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [7:0]  POLY       = CRC8_POLY_DEFAULT,
    parameter logic [7:0]  INIT       = CRC8_INIT_DEFAULT,
    parameter logic [7:0]  XOROUT     = 8'h00
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [DATA_WIDTH/8-1:0] s_keep,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [7:0]              m_crc
`ifdef CRC8_CHECK_EN
    ,
    input  logic [7:0]              s_crc_rx,
    output logic                    m_err,
    output logic [15:0]             err_cnt
`endif
);

    logic [7:0] crc_acc;
    logic [7:0] fold_out;
    logic [7:0] crc_fin;
    logic       beat;
    logic       done;

    // The slot accepts a beat whenever it is empty or being drained this cycle,
    // which gives full throughput with m_ready held high.
    assign s_ready = axi_resetn && (!m_valid || m_ready);
    assign beat    = s_valid && s_ready;
    assign done    = beat && s_last;
    assign crc_fin = fold_out ^ XOROUT;

    crc8_fold #(
        .DATA_WIDTH (DATA_WIDTH),
        .POLY       (POLY)
    ) u_fold (
        .crc_in  (crc_acc),
        .data    (s_data),
        .keep    (s_keep),
        .mask_en (s_last),
        .crc_out (fold_out)
    );

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            crc_acc <= INIT;
            m_valid <= 1'b0;
            m_crc   <= 8'h00;
        end else begin
            crc_acc <= beat ? (s_last ? INIT : fold_out) : crc_acc;
            m_valid <= done ? 1'b1 : (m_ready ? 1'b0 : m_valid);
            m_crc   <= done ? crc_fin : m_crc;
        end
    end

`ifdef CRC8_CHECK_EN
    // m_err is captured alongside m_crc so both stay stable while stalled;
    // the counter advances on the handshake that retires an erroneous result.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            m_err   <= 1'b0;
            err_cnt <= 16'h0000;
        end else begin
            m_err   <= done ? (crc_fin != s_crc_rx) : m_err;
            err_cnt <= (m_valid && m_ready && m_err && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
        end
    end
`else
    // Generator-only build: no received-CRC compare state.
`endif

endmodule
